// File: rtl/mem_access_unit.sv
// Load/store initiator between the core and a word-only data memory.
// Sub-word stores are read-modify-write; misaligned, out-of-range and illegal requests are rejected.
module mem_access_unit #(
  parameter int WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
  // valid-side payload is held stable until that edge.

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] buf_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_hs;
  logic        req_bad;
  logic        size_legal;
  logic [31:0] rd_shifted;
  logic [31:0] ld_data;
  logic [31:0] merged;

  assign req_ready  = (state_q == IDLE);
  assign req_hs     = req_valid & req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

  always_comb begin
    size_legal = 1'b0;
    case (req_size)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_legal = 1'b1;
      default:                                size_legal = 1'b0;
    endcase
  end

  assign req_bad = !size_legal
                || (req_we && req_size[2])
                || ((req_size[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
                || ((req_size[1:0] == 2'b01) && req_addr[0])
                || (req_addr[31:2] >= 30'(WORDS));

  // Half accesses are 2-byte aligned, so the byte-lane shift also selects the right half.
  assign rd_shifted = mem_read_data >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_data = rd_shifted;
    case (size_q)
      3'b000:  ld_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  ld_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b100:  ld_data = {24'd0, rd_shifted[7:0]};
      3'b101:  ld_data = {16'd0, rd_shifted[15:0]};
      default: ld_data = rd_shifted;
    endcase
  end

  always_comb begin
    merged = buf_q;
    case (size_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    mem_address      = 32'd0;
    mem_write_data   = 32'd0;
    mem_write_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          if (req_bad)                              state_d = RESP;
          else if (req_we && req_size[1:0] == 2'b10) state_d = WR;
          else                                      state_d = RD;
        end
      end
      RD: begin
        mem_address = {addr_q[31:2], 2'b00};
        state_d     = we_q ? WR : RESP;
      end
      WR: begin
        mem_address      = {addr_q[31:2], 2'b00};
        mem_write_data   = merged;
        mem_write_enable = 1'b1;
        state_d          = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      buf_q   <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        we_q    <= req_we;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= 32'd0;
        err_q   <= req_bad;
      end
      if (state_q == RD) begin
        buf_q <= mem_read_data;
        if (!we_q) rdata_q <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized requests
// compared against an arithmetic reference model of memory and responses.
module tb_mem_access_unit;

  localparam int WORDS = 64;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;
  logic [1:0]  dbg_state;

  logic [31:0] mem [0:WORDS-1];
  logic [31:0] ref_mem [0:WORDS-1];
  int          wr_count;
  int          n_checks;
  int          n_errors;

  mem_access_unit #(.WORDS(WORDS)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_size         (req_size),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word memory: combinational read, posedge write
  assign mem_read_data = (mem_address[31:2] < WORDS) ? mem[mem_address[7:2]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (mem_write_enable) begin
      if (mem_address[31:2] < WORDS) mem[mem_address[7:2]] <= mem_write_data;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    mem[idx]     = val;
    ref_mem[idx] = val;
  endtask

  // reference: response, latency, write cycle and updated word from the access rules
  function automatic void ref_model(input logic we, input logic [2:0] size,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    output logic err, output logic [31:0] rdata,
                                    output int lat, output int wc, output logic [31:0] new_word);
    int          nbytes;
    int          sh;
    logic        legal;
    logic [31:0] word;
    logic [31:0] val;
    logic [63:0] mask;
    legal    = size inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    nbytes   = 1 << size[1:0];
    err      = !legal || (we && size[2]) || ((addr % nbytes) != 0) || ((addr / 4) >= WORDS);
    rdata    = 32'd0;
    wc       = 0;
    new_word = 32'd0;
    lat      = 1;
    if (err) return;
    word     = ref_mem[addr[7:2]];
    new_word = word;
    sh       = 8 * int'(addr % 4);
    if (!we) begin
      val = word >> sh;
      case (size)
        3'b000:  rdata = {{24{val[7]}}, val[7:0]};
        3'b001:  rdata = {{16{val[15]}}, val[15:0]};
        3'b100:  rdata = {24'd0, val[7:0]};
        3'b101:  rdata = {16'd0, val[15:0]};
        default: rdata = word;
      endcase
      lat = 2;
    end else begin
      mask     = ((64'd1 << (8 * nbytes)) - 64'd1) << sh;
      new_word = (word & ~mask[31:0]) | ((wdata << sh) & mask[31:0]);
      lat      = (nbytes == 4) ? 2 : 3;
      wc       = lat - 1;
    end
  endfunction

  // driver: issue one request, check timing/response, hold resp_ready low for 'hold' cycles
  task automatic run_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold,
                         output logic [31:0] seen_rdata, output logic seen_err);
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_word;
    int          exp_lat, exp_wc;
    int          lat, wc, pulses, wr0;
    ref_model(we, size, addr, wdata, exp_err, exp_rdata, exp_lat, exp_wc, exp_word);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    wr0        = wr_count;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; wc = 0; pulses = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      if (mem_write_enable) begin
        pulses++;
        if (wc == 0) wc = c;
      end
      if (resp_valid) lat = c;
      else begin
        @(posedge clk); #1;
      end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("wr_cycle", 32'(wc), 32'(exp_wc));
    check("wr_pulses", 32'(pulses), (exp_wc != 0) ? 32'd1 : 32'd0);
    seen_rdata = resp_rdata;
    seen_err   = resp_err;
    check("rdata", resp_rdata, exp_rdata);
    check("err", 32'(resp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, exp_rdata);
      check("hold_err", 32'(resp_err), 32'(exp_err));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("resp_drop", 32'(resp_valid), 32'd0);
    check("wr_total", 32'(wr_count - wr0), (exp_wc != 0) ? 32'd1 : 32'd0);
    if (!exp_err) begin
      ref_mem[addr[7:2]] = exp_word;
      check("mem_word", mem[addr[7:2]], ref_mem[addr[7:2]]);
    end else if ((addr / 4) < WORDS) begin
      check("mem_untouched", mem[addr[7:2]], ref_mem[addr[7:2]]);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    logic [2:0]  sz;
    logic [31:0] ad;
    int          wr0;
    n_checks   = 0;
    n_errors   = 0;
    wr_count   = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;
    for (int i = 0; i < WORDS; i++) poke(i, $urandom);

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_we", 32'(mem_write_enable), 32'd0);
    check("rst_mem_addr", mem_address, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // signed/unsigned sub-word loads
    poke(1, 32'h8899_AABB);
    run_req(1'b0, 3'b000, 32'h5, 32'd0, 0, r, e);
    check("t1_lb", r, 32'hFFFF_FFAA);
    run_req(1'b0, 3'b101, 32'h6, 32'd0, 0, r, e);
    check("t2_lhu", r, 32'h0000_8899);
    run_req(1'b0, 3'b001, 32'h6, 32'd0, 0, r, e);
    check("t2_lh", r, 32'hFFFF_8899);

    // byte store read-modify-write
    poke(2, 32'h1122_3344);
    run_req(1'b1, 3'b000, 32'hA, 32'hFFFF_FFEE, 0, r, e);
    check("t3_sb_word", mem[2], 32'h11EE_3344);

    // rejected requests
    poke(0, 32'hCAFE_F00D);
    run_req(1'b1, 3'b010, 32'h2, 32'h1234_5678, 0, r, e);
    check("t4_sw_mis_err", 32'(e), 32'd1);
    check("t4_sw_mis_mem", mem[0], 32'hCAFE_F00D);
    run_req(1'b0, 3'b010, 32'h100, 32'd0, 0, r, e);
    check("t4_lw_oor_err", 32'(e), 32'd1);
    run_req(1'b1, 3'b100, 32'h10, 32'd0, 0, r, e);
    run_req(1'b0, 3'b011, 32'h10, 32'd0, 0, r, e);

    // response back-pressure
    run_req(1'b0, 3'b010, 32'h4, 32'd0, 3, r, e);
    check("t5_lw", r, 32'h8899_AABB);

    // reset during the read phase of a halfword store
    poke(3, 32'h5566_7788);
    req_valid = 1'b1; req_we = 1'b1; req_size = 3'b001;
    req_addr  = 32'hE; req_wdata = 32'h0000_ABCD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wr0 = wr_count;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t6_req_ready", 32'(req_ready), 32'd1);
    check("t6_resp_valid", 32'(resp_valid), 32'd0);
    check("t6_mem_we", 32'(mem_write_enable), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_write", 32'(wr_count - wr0), 32'd0);
    check("t6_mem_word", mem[3], 32'h5566_7788);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      sz = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) ad = $urandom;
      else                           ad = 32'($urandom_range(0, 4 * WORDS - 1));
      run_req(1'($urandom_range(0, 1)), sz, ad, $urandom, $urandom_range(0, 2), r, e);
    end
    for (int i = 0; i < WORDS; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
